ct_idu_is_aiq_lch_rdy_create: RTL

Create-side generator for the per-entry AIQ launch-ready registers. It accepts up to two dispatch creates per cycle and allocates free AIQ entries to them. For each create it computes a per-pipe source match against the producers launching that cycle. It drives registered create0/create1 dp-enables, one-hot entry selects and src_match vectors into the entry array. It also frees entries on launch and handles flush.

---
 rtl/ct_idu_is_pkg.sv | 13 +
 rtl/ct_idu_is_free_alloc2.sv | 27 ++
 rtl/ct_idu_is_aiq_lch_rdy_create.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/ct_idu_is_pkg.sv
// Shared sizes and types for the AIQ issue-stage launch-ready create slice.
// Holds entry-count, pipe-count and preg-width defaults plus vector types.
package ct_idu_is_pkg;

   localparam int AIQ_NUM_ENTRY = 8;
   localparam int AIQ_WIDTH     = 2;
   localparam int AIQ_PREG_W    = 7;

   typedef logic [AIQ_NUM_ENTRY-1:0] entry_vec_t;
   typedef logic [AIQ_PREG_W-1:0]    preg_t;
   typedef preg_t [AIQ_WIDTH-1:0]    lch_preg_arr_t;

endpackage

// File: rtl/ct_idu_is_free_alloc2.sv
// Two-lowest-set-bit finder: returns one-hot of the lowest and second-lowest
// set bits of vec, each with a found flag. Ports: vec in, *_oh/*_vld out.
module ct_idu_is_free_alloc2
   import ct_idu_is_pkg::*;
#(
   parameter int N = AIQ_NUM_ENTRY
) (
   input  logic [N-1:0] vec,
   output logic [N-1:0] first_oh,
   output logic         first_vld,
   output logic [N-1:0] second_oh,
   output logic         second_vld
);

   logic [N-1:0] one;
   logic [N-1:0] rest;

   assign one = {{(N-1){1'b0}}, 1'b1};

   // x & (~x + 1) isolates the lowest set bit
   assign first_oh   = vec & (~vec + one);
   assign first_vld  = |vec;
   assign rest       = vec & ~first_oh;
   assign second_oh  = rest & (~rest + one);
   assign second_vld = |rest;

endmodule

// File: rtl/ct_idu_is_aiq_lch_rdy_create.sv
// AIQ create-side launch-ready generator: allocates up to two free entries per
// cycle, registers create enables, one-hot entries and per-pipe src matches.
// Ports: forever_cpuclk/cpurst (sync, active high), rtu_flush, dis_create0/1
// vld+src_preg, lch_vld/lch_preg/lch_free in; dis_create_rdy, y_create0/1
// dp_en/entry/src_match and free_cnt out.
// Option: CT_IDU_LCH_RDY_LATE_MATCH_EN also ORs a compare of the held create
// src preg against the current-cycle launch into the output src_match.
module ct_idu_is_aiq_lch_rdy_create
   import ct_idu_is_pkg::*;
#(
   parameter int NUM_ENTRY = AIQ_NUM_ENTRY,
   parameter int WIDTH     = AIQ_WIDTH,
   parameter int PREG_W    = AIQ_PREG_W
) (
   input  logic                           forever_cpuclk,
   input  logic                           cpurst,
   input  logic                           rtu_flush,
   input  logic                           dis_create0_vld,
   input  logic [PREG_W-1:0]              dis_create0_src_preg,
   input  logic                           dis_create1_vld,
   input  logic [PREG_W-1:0]              dis_create1_src_preg,
   input  logic [WIDTH-1:0]               lch_vld,
   input  logic [WIDTH*PREG_W-1:0]        lch_preg,
   input  logic [NUM_ENTRY-1:0]           lch_free,
   output logic                           dis_create_rdy,
   output logic                           y_create0_dp_en,
   output logic [NUM_ENTRY-1:0]           y_create0_entry,
   output logic [WIDTH-1:0]               y_create0_src_match,
   output logic                           y_create1_dp_en,
   output logic [NUM_ENTRY-1:0]           y_create1_entry,
   output logic [WIDTH-1:0]               y_create1_src_match,
   output logic [$clog2(NUM_ENTRY+1)-1:0] free_cnt
);

   localparam int CW = $clog2(NUM_ENTRY+1);

   logic [NUM_ENTRY-1:0] free_q;
   logic [NUM_ENTRY-1:0] free_nxt;
   logic [NUM_ENTRY-1:0] rel;
   logic [NUM_ENTRY-1:0] first_oh;
   logic [NUM_ENTRY-1:0] second_oh;
   logic                 first_vld;
   logic                 second_vld;
   logic                 acc0;
   logic                 acc1;
   logic [NUM_ENTRY-1:0] ent0;
   logic [NUM_ENTRY-1:0] ent1;
   logic [CW-1:0]        cnt_nxt;
   logic [WIDTH-1:0]     match0;
   logic [WIDTH-1:0]     match1;
   logic [WIDTH-1:0]     sm0_q;
   logic [WIDTH-1:0]     sm1_q;

   // Two-slot rule: ready only with room for both ports, whatever is valid
   assign dis_create_rdy = (free_cnt >= CW'(2)) && !rtu_flush;

   assign acc0 = dis_create0_vld && dis_create_rdy;
   assign acc1 = dis_create1_vld && dis_create_rdy;

   ct_idu_is_free_alloc2 #(
      .N (NUM_ENTRY)
   ) x_alloc (
      .vec        (free_q),
      .first_oh   (first_oh),
      .first_vld  (first_vld),
      .second_oh  (second_oh),
      .second_vld (second_vld)
   );

   // Create1 takes the lowest entry when create0 is not accepted
   assign ent0 = (acc0 && first_vld) ? first_oh : '0;
   assign ent1 = !acc1 ? '0
               : acc0  ? (second_vld ? second_oh : '0)
               :         (first_vld  ? first_oh  : '0);

   // Frees of already-free entries are dropped; allocation saw free_q only
   assign rel      = lch_free & ~free_q;
   assign free_nxt = (free_q & ~(ent0 | ent1)) | rel;

   always_comb begin
      cnt_nxt = '0;
      for (int i = 0; i < NUM_ENTRY; i++) begin
         cnt_nxt = cnt_nxt + CW'(free_nxt[i]);
      end
   end

   for (genvar i = 0; i < WIDTH; i++) begin : g_match
      assign match0[i] = lch_vld[i]
         && (lch_preg[i*PREG_W +: PREG_W] == dis_create0_src_preg);
      assign match1[i] = lch_vld[i]
         && (lch_preg[i*PREG_W +: PREG_W] == dis_create1_src_preg);
   end

   always_ff @(posedge forever_cpuclk) begin
      if (cpurst || rtu_flush) begin
         free_q          <= '1;
         free_cnt        <= CW'(NUM_ENTRY);
         y_create0_dp_en <= 1'b0;
         y_create0_entry <= '0;
         sm0_q           <= '0;
         y_create1_dp_en <= 1'b0;
         y_create1_entry <= '0;
         sm1_q           <= '0;
      end else begin
         free_q          <= free_nxt;
         free_cnt        <= cnt_nxt;
         y_create0_dp_en <= acc0;
         y_create0_entry <= ent0;
         sm0_q           <= acc0 ? match0 : '0;
         y_create1_dp_en <= acc1;
         y_create1_entry <= ent1;
         sm1_q           <= acc1 ? match1 : '0;
      end
   end

`ifdef CT_IDU_LCH_RDY_LATE_MATCH_EN
   logic [PREG_W-1:0] src0_q;
   logic [PREG_W-1:0] src1_q;
   logic [WIDTH-1:0]  late0;
   logic [WIDTH-1:0]  late1;

   always_ff @(posedge forever_cpuclk) begin
      if (cpurst) begin
         src0_q <= '0;
         src1_q <= '0;
      end else begin
         src0_q <= dis_create0_src_preg;
         src1_q <= dis_create1_src_preg;
      end
   end

   // Catches producers launching while the create is written into the entry
   for (genvar i = 0; i < WIDTH; i++) begin : g_late
      assign late0[i] = y_create0_dp_en && lch_vld[i]
         && (lch_preg[i*PREG_W +: PREG_W] == src0_q);
      assign late1[i] = y_create1_dp_en && lch_vld[i]
         && (lch_preg[i*PREG_W +: PREG_W] == src1_q);
   end

   assign y_create0_src_match = sm0_q | late0;
   assign y_create1_src_match = sm1_q | late1;
`else
   assign y_create0_src_match = sm0_q;
   assign y_create1_src_match = sm1_q;
`endif

   a_free_busy_only : assert property (
      @(posedge forever_cpuclk) disable iff (cpurst || rtu_flush)
      !(|(lch_free & free_q))
   );

   a_entry_disjoint : assert property (
      @(posedge forever_cpuclk) disable iff (cpurst)
      !(|(y_create0_entry & y_create1_entry))
   );

endmodule
